// File: rtl/spiking_array_controller.sv
// rtl/spiking_array_controller.sv - load/compute/drain sequencer for the spiking systolic array
module spiking_array_controller #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     abort,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS-1:0]          in_spikes,
  input  logic [COLS*DATA_W-1:0]   in_weights,
  output logic [ROWS-1:0]          row_w_en,
  output logic [COLS-1:0]          col_w_en,
  output logic [ROWS-1:0]          row_r_en,
  output logic [COLS-1:0]          col_r_en,
  output logic [ROWS-1:0]          row_data,
  output logic [COLS*DATA_W-1:0]   col_data,
  output logic                     arr_rstn,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CNT_W = LEN_W + 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic              arr_rstn_q;
  logic              busy_q;
  logic              err_q;

  logic              len_ok;
  logic              start_ok;
  logic              abort_hit;
  logic              beat;
  logic              reading;
  logic              cnt_adv;
  logic              last_len;
  logic              last_drain;

  assign len_ok     = (len != '0) && (len <= LEN_W'(DEPTH));
  assign start_ok   = (state == S_IDLE) && start && len_ok;
  assign abort_hit  = abort && (state != S_IDLE);
  assign last_len   = (cnt == CNT_W'(len_q) - CNT_W'(1));
  assign last_drain = (cnt == CNT_W'(ROWS + COLS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; abort overrides every non-idle transition
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (start_ok) state_n = S_LOAD;
      S_LOAD:    if (beat && last_len) state_n = S_COMPUTE;
      S_COMPUTE: if (last_len) state_n = S_DRAIN;
      S_DRAIN:   if (last_drain) state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (abort_hit) state_n = S_IDLE;
  end

  // Output logic; the first LOAD cycle is recognised by the clear still being applied
  always_comb begin
    in_ready = (state == S_LOAD) && arr_rstn_q && !abort;
    beat     = in_valid && in_ready;
    reading  = (state == S_COMPUTE) && !abort;
    row_w_en = {ROWS{beat}};
    col_w_en = {COLS{beat}};
    row_r_en = {ROWS{reading}};
    col_r_en = {COLS{reading}};
    row_data = in_spikes;
    col_data = in_weights;
    done     = (state == S_DONE) && !abort;
  end

  always_comb begin
    cnt_adv = 1'b0;
    case (state)
      S_LOAD:             cnt_adv = beat;
      S_COMPUTE, S_DRAIN: cnt_adv = 1'b1;
      default:            cnt_adv = 1'b0;
    endcase
  end

  // Shared counter restarts from zero on every state change
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else if (cnt_adv) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      len_q      <= '0;
      arr_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (start_ok) len_q <= len;
      arr_rstn_q <= !(start_ok || abort_hit);
      busy_q     <= (state_n == S_LOAD) || (state_n == S_COMPUTE) || (state_n == S_DRAIN);
      err_q      <= (state == S_IDLE) && start && !len_ok;
    end
  end

  assign arr_rstn = arr_rstn_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spiking_array_controller.sv
// tb/tb_spiking_array_controller.sv - scoreboard bench: job-level model predicts timed output events
module tb_spiking_array_controller;

  localparam int ROWS   = 2;
  localparam int COLS   = 2;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = 3;
  localparam int DW     = ROWS + COLS * DATA_W;

  localparam int EV_CL = 0;
  localparam int EV_BR = 1;
  localparam int EV_W  = 2;
  localparam int EV_R  = 3;
  localparam int EV_BF = 4;
  localparam int EV_D  = 5;
  localparam int EV_E  = 6;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   start;
  logic [LEN_W-1:0]       len;
  logic                   abort;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS-1:0]        in_spikes;
  logic [COLS*DATA_W-1:0] in_weights;
  logic [ROWS-1:0]        row_w_en;
  logic [COLS-1:0]        col_w_en;
  logic [ROWS-1:0]        row_r_en;
  logic [COLS-1:0]        col_r_en;
  logic [ROWS-1:0]        row_data;
  logic [COLS*DATA_W-1:0] col_data;
  logic                   arr_rstn;
  logic                   busy;
  logic                   done;
  logic                   err;

  spiking_array_controller #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes), .in_weights(in_weights),
    .row_w_en(row_w_en), .col_w_en(col_w_en), .row_r_en(row_r_en), .col_r_en(col_r_en),
    .row_data(row_data), .col_data(col_data), .arr_rstn(arr_rstn), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;
    int            cyc;
    logic [DW-1:0] data;
  } ev_t;

  ev_t                    exp_q[$];
  int                     checks = 0;
  int                     errors = 0;
  bit                     mon_en = 1'b0;
  logic                   busy_prev = 1'b0;
  logic [ROWS-1:0]        b_spk[DEPTH];
  logic [COLS*DATA_W-1:0] b_w[DEPTH];
  int                     b_gap[DEPTH];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push_ev(int kind, int c, logic [DW-1:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void check_ev(int kind, logic [DW-1:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event actual kind=%0d cycle=%0d data=%h required no event", kind, cyc, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == EV_W && d !== e.data)) begin
        errors++;
        $display("FAIL event actual kind=%0d cycle=%0d data=%h required kind=%0d cycle=%0d data=%h",
                 kind, cyc, d, e.kind, e.cyc, e.data);
      end
    end
  endfunction

  // Monitor: turns observed pin activity into events, in a fixed per-cycle order
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (arr_rstn !== 1'b1) check_ev(EV_CL, '0);
        if (busy === 1'b1 && busy_prev === 1'b0) check_ev(EV_BR, '0);
        if ((|row_w_en) || (|col_w_en)) begin
          chk("w_en_all", 64'({row_w_en, col_w_en}), 64'({(ROWS + COLS){1'b1}}));
          check_ev(EV_W, {row_data, col_data});
        end
        if ((|row_r_en) || (|col_r_en)) begin
          chk("r_en_all", 64'({row_r_en, col_r_en}), 64'({(ROWS + COLS){1'b1}}));
          check_ev(EV_R, '0);
        end
        chk("wr_exclusive", 64'(((|row_w_en) || (|col_w_en)) && ((|row_r_en) || (|col_r_en))), 64'd0);
        if (busy === 1'b0 && busy_prev === 1'b1) check_ev(EV_BF, '0);
        if (done === 1'b1) check_ev(EV_D, '0);
        if (err === 1'b1) check_ev(EV_E, '0);
      end
      busy_prev = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; len = '0;
    in_spikes = ROWS'($urandom); in_weights = COLS*DATA_W'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Job-level model: job issued in cycle b means LOAD starts at b+1, clear at b+1,
  // beats from b+2 stretched by gaps, len read cycles, ROWS+COLS drain cycles, then done.
  task automatic run_job(input int l, input int abort_k, input bit abort_with_start, input bit busy_starts);
    int b;
    int t;
    int t_last;
    int end_rel;
    int beat_rel[DEPTH];
    b = cyc;
    push_ev(EV_CL, b + 1, '0);
    push_ev(EV_BR, b + 1, '0);
    t = 2;
    for (int i = 0; i < l; i++) begin
      t += b_gap[i];
      beat_rel[i] = t;
      push_ev(EV_W, b + t, {b_spk[i], b_w[i]});
      t++;
    end
    t_last = beat_rel[l-1];
    if (abort_k == 0) begin
      for (int k = 1; k <= l; k++) push_ev(EV_R, b + t_last + k, '0);
      end_rel = t_last + l + ROWS + COLS + 1;
      push_ev(EV_BF, b + end_rel, '0);
      push_ev(EV_D, b + end_rel, '0);
    end else begin
      for (int k = 1; k < abort_k; k++) push_ev(EV_R, b + t_last + k, '0);
      end_rel = t_last + abort_k + 1;
      push_ev(EV_CL, b + end_rel, '0);
      push_ev(EV_BF, b + end_rel, '0);
    end
    idle_inputs();
    start = 1'b1;
    len   = LEN_W'(l);
    abort = abort_with_start;
    for (int rel = 1; rel <= end_rel; rel++) begin
      tick();
      idle_inputs();
      if (rel == 1) begin
        in_valid = 1'b1; in_spikes = b_spk[0]; in_weights = b_w[0];
      end
      for (int i = 0; i < l; i++) begin
        if (beat_rel[i] == rel) begin
          in_valid = 1'b1; in_spikes = b_spk[i]; in_weights = b_w[i];
        end
      end
      if (rel == t_last + 1) in_valid = 1'b1;
      if (abort_k != 0 && rel == t_last + abort_k) abort = 1'b1;
      if (busy_starts && abort_k == 0 && (rel == 2 || rel == t_last + l + 2)) begin
        start = 1'b1;
        len   = LEN_W'($urandom_range(1, DEPTH));
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic bad_start(input int l);
    push_ev(EV_E, cyc + 1, '0);
    idle_inputs();
    start = 1'b1;
    len   = LEN_W'(l);
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic random_beats(input int l, input int gap_max);
    for (int i = 0; i < DEPTH; i++) begin
      b_spk[i] = ROWS'($urandom);
      b_w[i]   = COLS*DATA_W'($urandom);
      b_gap[i] = (i < l) ? $urandom_range(0, gap_max) : 0;
    end
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_enables"}, 64'({row_w_en, col_w_en, row_r_en, col_r_en}), 64'd0);
    chk({tag, "_arr_rstn"}, 64'(arr_rstn), 64'd0);
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    repeat (3) tick();
    check_reset_outputs("por");
    rstn = 1'b1;
    tick();
    chk("por_release_arr_rstn", 64'(arr_rstn), 64'd1);
    chk("por_release_busy", 64'(busy), 64'd0);

    // Reset mid-LOAD after one beat has been written
    start = 1'b1; len = LEN_W'(3);
    tick();
    idle_inputs();
    tick();
    in_valid = 1'b1;
    tick();
    rstn = 1'b0;
    in_valid = 1'b1;
    start = 1'b1; len = LEN_W'(2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_outputs("midload_rst");
    end
    rstn = 1'b1;
    idle_inputs();
    tick();
    chk("rst_release_arr_rstn", 64'(arr_rstn), 64'd1);
    chk("rst_release_busy", 64'(busy), 64'd0);
    chk("rst_release_in_ready", 64'(in_ready), 64'd0);
    tick();
    mon_en = 1'b1;
    tick();

    // Nominal: weights given as (col0, col1); -21 = 16'hFFEB, -30 = 16'hFFE2
    b_spk[0] = 2'b01; b_w[0] = {16'h0000, 16'h000E}; b_gap[0] = 0;
    b_spk[1] = 2'b10; b_w[1] = {16'h0017, 16'hFFEB}; b_gap[1] = 0;
    b_spk[2] = 2'b10; b_w[2] = {16'hFFE2, 16'h0000}; b_gap[2] = 0;
    run_job(3, 0, 1'b0, 1'b0);
    tick();

    random_beats(2, 0);
    b_gap[1] = 2;
    run_job(2, 0, 1'b0, 1'b0);
    tick();

    bad_start(0);
    bad_start(5);
    bad_start(7);

    random_beats(3, 0);
    run_job(3, 2, 1'b0, 1'b0);
    random_beats(1, 0);
    run_job(1, 0, 1'b0, 1'b0);

    random_beats(2, 1);
    run_job(2, 0, 1'b0, 1'b1);

    random_beats(2, 1);
    run_job(2, 0, 1'b1, 1'b0);

    for (int j = 0; j < 30; j++) begin
      int l;
      int ak;
      l  = $urandom_range(1, DEPTH);
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, l) : 0;
      random_beats(l, 2);
      run_job(l, ak, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) bad_start(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(5, 7));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (4) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spiking_array_controller.md
# spiking_array_controller

Sequencer for the ROWS x COLS spiking systolic array and its row/column input FIFOs. It accepts a job of `len` input beats over a valid/ready stream and writes them into all FIFOs in lockstep. It then reads the FIFOs into the array for exactly `len` cycles, waits out the array's diagonal skew, and pulses `done` when the array outputs are final. It sits between the host/DMA stream and the array's `*_w_en`, `*_r_en`, `in_row_*`, `in_col_*` and `rstn` pins.

## Interface
- `ROWS`, 2, number of array rows (spike-input FIFOs)
- `COLS`, 2, number of array columns (weight FIFOs)
- `DATA_W`, 16, signed weight width
- `DEPTH`, 4, FIFO depth; maximum job length
- `LEN_W`, $clog2(DEPTH+1), width of `len`
- `clk` in 1: single clock; all logic on the rising edge.
- `rstn` in 1: reset, synchronous and active-low.
- `start` in 1: job request; sampled only in IDLE.
- `len` in LEN_W: beats in the job; valid range is 1..DEPTH.
- `abort` in 1: synchronous job cancel.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: controller accepts a beat.
- `in_spikes` in ROWS: one spike bit per row.
- `in_weights` in COLS*DATA_W: column c occupies bits [c*DATA_W +: DATA_W].
- `row_w_en` out ROWS: row FIFO write enables.
- `col_w_en` out COLS: column FIFO write enables.
- `row_r_en` out ROWS: row FIFO read enables.
- `col_r_en` out COLS: column FIFO read enables.
- `row_data` out ROWS: spikes to the row FIFOs.
- `col_data` out COLS*DATA_W: weights to the column FIFOs.
- `arr_rstn` out 1: active-low clear to the array and FIFOs.
- `busy` out 1: high in LOAD, COMPUTE and DRAIN.
- `done` out 1: one-cycle pulse when the result is final.
- `err` out 1: one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE. A 2-bit-plus encoding is free.
- IDLE:
  - `start` with 1 ≤ `len` ≤ DEPTH latches `len` into `len_q`, clears the beat counter and goes to LOAD.
  - `start` with `len`=0 or `len`>DEPTH stays in IDLE and pulses `err` on the next cycle.
- Clear: `arr_rstn` is registered. It is 0 for exactly the first LOAD cycle after an accepted start, and 1 otherwise.
- LOAD:
  - `in_ready`=1, except in the first LOAD cycle, where it is 0 while the clear is applied.
  - A beat is accepted when `in_valid & in_ready`.
  - On an accepted beat, all `row_w_en` and `col_w_en` bits equal 1 combinationally in that cycle.
  - `row_data`/`col_data` are a combinational pass-through of `in_spikes`/`in_weights` and are don't-care otherwise.
  - After `len_q` beats are accepted, the next state is COMPUTE.
- COMPUTE: all `row_r_en`/`col_r_en` = 1 for exactly `len_q` consecutive cycles, then DRAIN.
- DRAIN: all enables are 0 for exactly ROWS+COLS cycles (skew flush), then DONE.
- DONE: one cycle with `done`=1 and `busy`=0, then IDLE.
- `abort`:
  - In any non-IDLE state, the next state is IDLE.
  - All enables go to 0 in the abort cycle, since they are gated combinationally.
  - `arr_rstn` is 0 in the following cycle.
  - No `done` pulse is produced.
  - If `abort` and `start` arrive together in IDLE, the start wins and `abort` is ignored.
- Counter: one LEN_W+2-bit counter is reused per state and reset to 0 on each state entry.
- `rstn`=0 (including mid-job) gives, at the next edge:
  - state IDLE and counter 0.
  - `in_ready`=0, `busy`=0, `done`=0, `err`=0.
  - all enables 0 and `arr_rstn`=0 (array held in reset with the controller).
  - `arr_rstn` returns to 1 on the first cycle after `rstn` is released.

## Timing
- Start accepted at edge 0 → first LOAD cycle is cycle 1 (clear); the earliest beat is in cycle 2.
- With `in_valid` held high, beats land in cycles 2..len+1.
- COMPUTE occupies cycles len+2..2len+1.
- DRAIN occupies 2len+2..2len+1+ROWS+COLS.
- `done` is high in cycle 2len+2+ROWS+COLS.
- Gaps in `in_valid` stretch LOAD one cycle per idle cycle. The COMPUTE/DRAIN durations never change.
- Write and read enables are never 1 in the same cycle.
- `busy` is registered and tracks state: high from cycle 1 through the last DRAIN cycle.
- `err` is registered, one cycle after the rejected start.

## Test plan
- Reset: hold `rstn`=0 for 3 cycles mid-LOAD → all outputs at reset values, state IDLE, `arr_rstn`=0. Release → `arr_rstn`=1 next cycle, `busy`=0.
- Nominal job, ROWS=COLS=2, len=3, `in_valid` continuous, beats {spk 2'b01, w (14,0)}, {2'b10, (-21,23)}, {2'b10, (0,-30)}:
  - w_en high in cycles 2–4 with data matching.
  - r_en high in cycles 5–7.
  - `done` in cycle 12, `busy` high in cycles 1–11.
- Backpressure: len=2 with `in_valid` low for 2 cycles between beats → exactly 2 write cycles, r_en for 2 cycles, `done` delayed by 2 versus the uninterrupted case.
- Illegal start: len=0, then len=5 (DEPTH=4) → `err` pulses each once, `busy` stays 0, no enables.
- Abort in COMPUTE (second read cycle) → enables drop in that cycle, IDLE next, `arr_rstn`=0 one cycle, no `done`. A following len=1 job completes normally.
- Start while busy: `start` pulsed in LOAD and DRAIN → ignored, job timing unchanged, no `err`.
